// File: rtl/rx_iq_buffer.sv
// rx_iq_buffer: show-ahead FIFO of decimated RX1/RX2 I/Q sample sets feeding
// the parallel-bus RX IQ burst. One entry per in_valid strobe, one pop per
// rising edge of IQ_RX_READ_CLK while IQ_RX_READ_REQ is high.
module rx_iq_buffer #(
  parameter int ADDR_W      = 6,
  parameter int READY_LEVEL = 16
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [23:0]       in_rx1_i,
  input  logic [23:0]       in_rx1_q,
  input  logic [23:0]       in_rx2_i,
  input  logic [23:0]       in_rx2_q,
  input  logic              IQ_RX_READ_REQ,
  input  logic              IQ_RX_READ_CLK,
  output logic [23:0]       RX1_I,
  output logic [23:0]       RX1_Q,
  output logic [23:0]       RX2_I,
  output logic [23:0]       RX2_Q,
  output logic [ADDR_W:0]   level,
  output logic              iq_ready,
  output logic              overrun,
  output logic              underrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] READY_THR   = (ADDR_W + 1)'(READY_LEVEL);

  logic [95:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rclk_d;
  logic              pop_req;
  logic              pop_ok;
  logic              wr_ok;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level_next;
  logic [95:0]       head;

  // Decode pop/write acceptance and the next occupancy.
  // A full FIFO still takes a write when a pop retires an entry on the same edge.
  always_comb begin
    full       = (level == FULL_LEVEL);
    empty      = (level == '0);
    pop_req    = IQ_RX_READ_CLK & ~rclk_d & IQ_RX_READ_REQ;
    pop_ok     = pop_req & ~empty;
    wr_ok      = in_valid & (~full | pop_ok);
    level_next = level;
    if (wr_ok && !pop_ok)
      level_next = level + 1'b1;
    else if (pop_ok && !wr_ok)
      level_next = level - 1'b1;
  end

  // Show-ahead head: zero whenever nothing is stored.
  always_comb begin
    head = empty ? '0 : mem[rd_ptr];
    {RX1_I, RX1_Q, RX2_I, RX2_Q} = head;
  end

  // Sample-set storage; no reset needed since level gates visibility.
  always_ff @(posedge clk_in) begin
    if (wr_ok && !flush)
      mem[wr_ptr] <= {in_rx1_i, in_rx1_q, in_rx2_i, in_rx2_q};
  end

  // Read-strobe edge detector keeps tracking even through flush.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)
      rclk_d <= 1'b0;
    else
      rclk_d <= IQ_RX_READ_CLK;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      iq_ready <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      iq_ready <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      level    <= level_next;
      iq_ready <= (level_next >= READY_THR);
      if (in_valid && !wr_ok)
        overrun <= 1'b1;
      if (pop_req && !pop_ok)
        underrun <= 1'b1;
    end
  end

endmodule
